// File: rtl/mux_4x1_arbiter.sv
// Round-robin arbiter sharing one 4:1 single-bit selector among four requesters.
// Optional per-owner hold limit is enabled by defining MUX_ARB_HOLD_LIMIT_EN.

module mux_4x1 (
  input  logic [3:0] d,
  input  logic [1:0] sel,
  output logic       y
);

  // Plain 4:1 selector for the shared data line.
  always_comb begin
    case (sel)
      2'd0:    y = d[0];
      2'd1:    y = d[1];
      2'd2:    y = d[2];
      2'd3:    y = d[3];
      default: y = 1'b0;
    endcase
  end

endmodule

module mux_4x1_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic [3:0] data,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       busy,
  output logic       out
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       state_q, state_d;
  logic [3:0]       grant_q, grant_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             out_q, out_d;
  logic [1:0]       winner_s;
  logic             mux_y_s;
  logic             hold_hit_s;

  // First requester found searching last+1, last+2, last+3, last (mod 4).
  function automatic logic [1:0] pick_winner(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    logic       found;
    pick_winner = last;
    found       = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && r[idx]) begin
        pick_winner = idx;
        found       = 1'b1;
      end else begin
        found = found;
      end
    end
  endfunction

  assign winner_s = pick_winner(req, last_q);

`ifdef MUX_ARB_HOLD_LIMIT_EN
  assign hold_hit_s = (cnt_q == CNT_W'(MAX_HOLD));
`else
  assign hold_hit_s = 1'b0;
`endif

  mux_4x1 u_mux (
    .d   (data),
    .sel (sel_q),
    .y   (mux_y_s)
  );

  // Next-state logic for ownership, rotation pointer and hold counter.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req != 4'b0000) begin
          state_d = GRANT;
          grant_d = 4'b0001 << winner_s;
          sel_d   = winner_s;
          last_d  = winner_s;
          cnt_d   = CNT_W'(1);
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (req[sel_q] && !hold_hit_s) begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end else begin
          // sel keeps the last owner through the release
          grant_d = 4'b0000;
          state_d = GAP;
        end
      end
      GAP: begin
        grant_d = 4'b0000;
        state_d = IDLE;
      end
      default: begin
        grant_d = 4'b0000;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == GRANT);
    out_d  = (state_q == GRANT) ? mux_y_s : 1'b0;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 4'b0000;
      sel_q   <= 2'b00;
      last_q  <= 2'd3;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      out_q   <= out_d;
    end
  end

  assign grant = grant_q;
  assign sel   = sel_q;
  assign busy  = busy_q;
  assign out   = out_q;

endmodule

// File: tb/tb_mux_4x1_arbiter.sv
// Self-checking bench for mux_4x1_arbiter: directed scenarios plus randomized
// traffic against an ownership-level reference model.
module tb_mux_4x1_arbiter;

  localparam int TB_MAX_HOLD = 3;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] data;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       busy;
  logic       out;

  int n_cmp;
  int n_err;

  // Reference model: who owns the line, and whether we are in the dead cycle.
  int   m_owner;
  bit   m_dead;
  int   m_last;
  int   m_sel;
  int   m_held;
  bit   m_out;

  logic [3:0] order_q[$];

  mux_4x1_arbiter #(.MAX_HOLD(TB_MAX_HOLD), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .data  (data),
    .grant (grant),
    .sel   (sel),
    .busy  (busy),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input logic [3:0] r, input logic [3:0] d, input logic rs);
    bit new_out;
    int c;
    if (rs) begin
      m_owner = -1; m_dead = 0; m_last = 3; m_sel = 0; m_held = 0; m_out = 0;
    end else begin
      new_out = (m_owner >= 0) ? d[m_owner] : 1'b0;
      if (m_owner >= 0) begin
`ifdef MUX_ARB_HOLD_LIMIT_EN
        if (!r[m_owner] || m_held == TB_MAX_HOLD) begin
`else
        if (!r[m_owner]) begin
`endif
          m_owner = -1;
          m_dead  = 1;
        end else begin
          m_held = (m_held < 15) ? m_held + 1 : 15;
        end
      end else if (m_dead) begin
        m_dead = 0;
      end else if (r != 4'b0000) begin
        for (int k = 1; k <= 4; k++) begin
          c = (m_last + k) % 4;
          if (m_owner < 0 && r[c]) m_owner = c;
        end
        m_last = m_owner;
        m_sel  = m_owner;
        m_held = 1;
      end
      m_out = new_out;
    end
  endtask

  // One clock: drive at negedge, let the edge happen, compare just after it.
  task automatic step(input logic [3:0] r, input logic [3:0] d, input logic rs);
    logic [3:0] eg;
    @(negedge clk);
    req = r; data = d; reset = rs;
    @(posedge clk);
    model_step(r, d, rs);
    #1;
    eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    check_eq("grant", {4'b0000, grant}, {4'b0000, eg});
    check_eq("sel", {6'b000000, sel}, 8'(m_sel));
    check_eq("busy", {7'b0000000, busy}, {7'b0000000, (m_owner >= 0)});
    check_eq("out", {7'b0000000, out}, {7'b0000000, m_out});
  endtask

  initial begin
    logic [3:0] r;
    n_cmp = 0; n_err = 0;
    req = 4'b0000; data = 4'b0000; reset = 1'b1;

    // Reset then idle
    step(4'b0000, 4'b0000, 1'b1);
    step(4'b0000, 4'b0000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(4'b0000, 4'($urandom), 1'b0);
      check_eq("idle_grant", {4'b0000, grant}, 8'h00);
      check_eq("idle_out", {7'b0000000, out}, 8'h00);
    end

    // Single request
    step(4'b0100, 4'b0100, 1'b0);
    check_eq("single_grant", {4'b0000, grant}, 8'h04);
    check_eq("single_sel", {6'b000000, sel}, 8'h02);
    check_eq("single_out_first", {7'b0000000, out}, 8'h00);
    step(4'b0100, 4'b0100, 1'b0);
    check_eq("single_out", {7'b0000000, out}, 8'h01);
    step(4'b0000, 4'b0100, 1'b0);
    check_eq("single_release", {4'b0000, grant}, 8'h00);
    step(4'b0000, 4'b0100, 1'b0);
    check_eq("single_out_off", {7'b0000000, out}, 8'h00);

    // Round robin: everyone requests, each owner drops req while granted
    step(4'b0000, 4'b0000, 1'b1);
    order_q.delete();
    for (int c = 0; c < 40 && order_q.size() < 5; c++) begin
      r = busy ? (4'b1111 & ~grant) : 4'b1111;
      step(r, 4'($urandom), 1'b0);
      if (grant != 4'b0000) order_q.push_back(grant);
    end
    check_eq("rr_count", 8'(order_q.size()), 8'd5);
    if (order_q.size() == 5) begin
      check_eq("rr0", {4'b0000, order_q[0]}, 8'h01);
      check_eq("rr1", {4'b0000, order_q[1]}, 8'h02);
      check_eq("rr2", {4'b0000, order_q[2]}, 8'h04);
      check_eq("rr3", {4'b0000, order_q[3]}, 8'h08);
      check_eq("rr4", {4'b0000, order_q[4]}, 8'h01);
    end

`ifndef MUX_ARB_HOLD_LIMIT_EN
    // Owner masking
    step(4'b0000, 4'b0000, 1'b1);
    step(4'b0001, 4'($urandom), 1'b0);
    check_eq("mask_start", {4'b0000, grant}, 8'h01);
    for (int i = 0; i < 6; i++) begin
      step(4'b1111, 4'($urandom), 1'b0);
      check_eq("mask_hold", {4'b0000, grant}, 8'h01);
    end
    step(4'b1110, 4'($urandom), 1'b0);
    check_eq("mask_gap", {4'b0000, grant}, 8'h00);
    step(4'b1110, 4'($urandom), 1'b0);
    check_eq("mask_idle", {4'b0000, grant}, 8'h00);
    step(4'b1110, 4'($urandom), 1'b0);
    check_eq("mask_next", {4'b0000, grant}, 8'h02);

    // No hold limit: owner keeps the line
    step(4'b0000, 4'b0000, 1'b1);
    for (int i = 0; i < 25; i++) begin
      step(4'b0011, 4'($urandom), 1'b0);
      check_eq("nolimit_hold", {4'b0000, grant}, 8'h01);
    end
`else
    // Hold limit: 3 granted, GAP, IDLE, then the other requester
    step(4'b0000, 4'b0000, 1'b1);
    for (int j = 0; j < 20; j++) begin
      int p;
      step(4'b0011, 4'($urandom), 1'b0);
      p = j % 10;
      check_eq("hold_pattern", {4'b0000, grant},
               (p < 3) ? 8'h01 : ((p >= 5 && p < 8) ? 8'h02 : 8'h00));
    end
`endif

    // Reset mid-grant
    step(4'b0000, 4'b0000, 1'b1);
    step(4'b1000, 4'b1000, 1'b0);
    check_eq("mid_grant", {4'b0000, grant}, 8'h08);
    step(4'b1000, 4'b1000, 1'b0);
    check_eq("mid_out", {7'b0000000, out}, 8'h01);
    step(4'b1000, 4'b1000, 1'b1);
    check_eq("mid_rst_grant", {4'b0000, grant}, 8'h00);
    check_eq("mid_rst_sel", {6'b000000, sel}, 8'h00);
    check_eq("mid_rst_out", {7'b0000000, out}, 8'h00);
    step(4'b1111, 4'b1111, 1'b0);
    check_eq("mid_after", {4'b0000, grant}, 8'h01);

    // Randomized traffic against the model
    r = 4'b0000;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      step(r, 4'($urandom), ($urandom_range(0, 99) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
